// File: rtl/pipelined_subtractor_if.sv
// Operand/result bundle shared by the pipelined subtractor and pipelined adder.
// master = upstream producer plus downstream consumer side; slave = the arithmetic block.
interface pipelined_subtractor_if #(
    parameter int w = 128
);
    logic [w-1:0] op1;
    logic [w-1:0] op2;
    logic         valid_op1;
    logic         valid_op2;
    logic         in_ready;
    logic [w-1:0] res;
    logic         borrow;
    logic         valid;
    logic         out_ready;

    modport master (
        output op1, op2, valid_op1, valid_op2, out_ready,
        input  in_ready, res, borrow, valid
    );

    modport slave (
        input  op1, op2, valid_op1, valid_op2, out_ready,
        output in_ready, res, borrow, valid
    );
endinterface

// File: rtl/pipelined_subtractor.sv
// Wide unsigned subtractor, one slice of w/s bits per pipeline stage, with the
// borrow rippling one slice per stage and output back-pressure freezing the pipe.
module pipelined_subtractor #(
    parameter int w = 128,
    parameter int s = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    pipelined_subtractor_if.slave bus
);
    localparam int sw = (s >= 1) ? (w / s) : 1;

    generate
        if ((s < 1) ? 1'b1 : ((w % s) != 0)) begin : g_bad_params
            $error("pipelined_subtractor: w must be a positive multiple of s, s >= 1");
        end
    endgenerate

    logic [w-1:0]  r_op1   [s];
    logic [w-1:0]  r_op2   [s];
    logic [w-1:0]  r_diff  [s];
    logic [s-1:0]  r_valid;
    logic [s-1:0]  r_borrow;
    logic [sw:0]   w_sub   [s];
    logic          w_stall;
    logic          w_accept;

    assign w_stall      = r_valid[s-1] & ~bus.out_ready;
    assign w_accept     = bus.valid_op1 & bus.valid_op2 & ~w_stall;
    assign bus.in_ready = ~w_stall;
    assign bus.res      = r_diff[s-1];
    assign bus.borrow   = r_borrow[s-1];
    assign bus.valid    = r_valid[s-1];

    // Per-slice (sw+1)-bit differences; the top bit of each is that slice's borrow-out.
    always_comb begin
        for (int k = 0; k < s; k++) begin
            w_sub[k] = '0;
        end
        w_sub[0] = {1'b0, bus.op1[sw-1:0]} - {1'b0, bus.op2[sw-1:0]};
        for (int k = 1; k < s; k++) begin
            w_sub[k] = {1'b0, sw'(r_op1[k-1] >> (k * sw))}
                     - {1'b0, sw'(r_op2[k-1] >> (k * sw))}
                     - {{sw{1'b0}}, r_borrow[k-1]};
        end
    end

    // Pipeline registers: whole pipe freezes on stall; data only moves with a valid entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid  <= '0;
            r_borrow <= '0;
            for (int k = 0; k < s; k++) begin
                r_op1[k]  <= '0;
                r_op2[k]  <= '0;
                r_diff[k] <= '0;
            end
        end else if (!w_stall) begin
            r_valid[0] <= w_accept;
            if (w_accept) begin
                r_op1[0]         <= bus.op1;
                r_op2[0]         <= bus.op2;
                r_diff[0]        <= '0;
                r_diff[0][sw-1:0] <= w_sub[0][sw-1:0];
                r_borrow[0]      <= w_sub[0][sw];
            end
            for (int k = 1; k < s; k++) begin
                r_valid[k] <= r_valid[k-1];
                if (r_valid[k-1]) begin
                    r_op1[k]               <= r_op1[k-1];
                    r_op2[k]               <= r_op2[k-1];
                    r_diff[k]              <= r_diff[k-1];
                    r_diff[k][k*sw +: sw]  <= w_sub[k][sw-1:0];
                    r_borrow[k]            <= w_sub[k][sw];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor: directed scenarios plus random
// traffic, checked every cycle against a queue-based latency/arithmetic model.
module tb_pipelined_subtractor;
    localparam int W = 128;
    localparam int S = 4;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    pipelined_subtractor_if #(.w(W)) bus ();

    pipelined_subtractor #(.w(W), .s(S)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         b;
        int           age;
    } ent_t;

    ent_t         q[$];
    logic [W-1:0] held_r;
    logic         held_b;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock cycle: drive, check against model, advance model, wait to next negedge.
    task automatic step(input logic v1, input logic v2, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy, output logic acc);
        logic ev;
        logic eir;
        bus.valid_op1 = v1;
        bus.valid_op2 = v2;
        bus.op1       = a;
        bus.op2       = b;
        bus.out_ready = ordy;
        #1;
        ev = (q.size() > 0) && (q[0].age == S);
        if (ev) begin
            held_r = q[0].r;
            held_b = q[0].b;
        end
        eir = !(ev && !ordy);
        chk("in_ready", {{(W-1){1'b0}}, bus.in_ready}, {{(W-1){1'b0}}, eir});
        chk("valid",    {{(W-1){1'b0}}, bus.valid},    {{(W-1){1'b0}}, ev});
        chk("res",      bus.res, held_r);
        chk("borrow",   {{(W-1){1'b0}}, bus.borrow},   {{(W-1){1'b0}}, held_b});
        acc = v1 && v2 && eir;
        if (eir) begin
            if (ev) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (acc) q.push_back('{r: a - b, b: (a < b), age: 1});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd128(), rnd128(), 1'b1, acc);
    endtask

    initial begin
        logic acc;
        int   nxt;
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_tests = 0;
        n_fail  = 0;
        held_r  = '0;
        held_b  = 1'b0;
        rstn    = 1'b1;
        bus.valid_op1 = 1'b0;
        bus.valid_op2 = 1'b0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.out_ready = 1'b1;
        #1 rstn = 1'b0;

        // Reset held for 3 cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.valid_op1 = 1'($urandom_range(0, 1));
            bus.valid_op2 = 1'($urandom_range(0, 1));
            bus.op1       = rnd128();
            bus.op2       = rnd128();
            bus.out_ready = 1'b1;
            @(negedge clk);
            #1;
            chk("rst_res",      bus.res, '0);
            chk("rst_borrow",   {{(W-1){1'b0}}, bus.borrow},   '0);
            chk("rst_valid",    {{(W-1){1'b0}}, bus.valid},    '0);
            chk("rst_in_ready", {{(W-1){1'b0}}, bus.in_ready}, {{(W-1){1'b0}}, 1'b1});
        end
        @(negedge clk);
        rstn = 1'b1;

        // Basic 5 - 3
        step(1'b1, 1'b1, 128'd5, 128'd3, 1'b1, acc);
        idle(6);

        // Full-width borrow, then cross-slice borrow
        step(1'b1, 1'b1, 128'd0, 128'd1, 1'b1, acc);
        step(1'b1, 1'b1, 128'h1_0000_0000, 128'd1, 1'b1, acc);
        idle(6);
        chk("fw_last_res", bus.res, 128'h0000_0000_FFFF_FFFF);

        // Streaming 8 ops with a 3-cycle stall when the first result appears
        nxt = 0;
        for (int c = 0; c < 24; c++) begin
            step(nxt < 8, nxt < 8, 128'(100 + nxt), 128'(nxt), !(c >= 4 && c <= 6), acc);
            if (acc) nxt++;
        end
        chk("stream_issued", 128'(nxt), 128'd8);

        // Only one operand valid for 5 cycles, then a single op 7 - 9
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd128(), rnd128(), 1'b1, acc);
        step(1'b1, 1'b1, 128'd7, 128'd9, 1'b1, acc);
        idle(6);
        chk("pv_res", bus.res, {{(W-1){1'b1}}, 1'b0});

        // Asynchronous reset with results in flight
        step(1'b1, 1'b1, 128'd50, 128'd20, 1'b1, acc);
        step(1'b1, 1'b1, 128'd60, 128'd20, 1'b1, acc);
        idle(2);
        bus.valid_op1 = 1'b0;
        bus.valid_op2 = 1'b0;
        #1;
        chk("pre_rst_valid", {{(W-1){1'b0}}, bus.valid}, {{(W-1){1'b0}}, 1'b1});
        #1 rstn = 1'b0;
        #1;
        chk("async_valid", {{(W-1){1'b0}}, bus.valid}, '0);
        chk("async_res",   bus.res, '0);
        q.delete();
        held_r = '0;
        held_b = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        idle(8);
        step(1'b1, 1'b1, 128'd10, 128'd4, 1'b1, acc);
        idle(3);
        chk("rst_new_res", bus.res, 128'd6);
        idle(2);

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            a = rnd128();
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a + 128'($urandom_range(0, 3));
                2:       b = {a[W-1:32], 32'($urandom())};
                default: b = rnd128();
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a, b,
                 $urandom_range(0, 3) != 0, acc);
        end
        idle(8);
        chk("drained", 128'(q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
